// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchroniser and bounce filter for a raw push-button.
//            Outputs a clean level, press/release pulses and a sticky flag.
//            Define KEY_LONGPRESS_EN to build the long-press detector.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 24,
  parameter int LONG_CYCLES     = 16_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic flag_clr,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic press_flag,
  output logic long_press
);

  localparam logic [1:0] ST_LO  = 2'd0;
  localparam logic [1:0] CHK_HI = 2'd1;
  localparam logic [1:0] ST_HI  = 2'd2;
  localparam logic [1:0] CHK_LO = 2'd3;

  localparam longint    CNT_LIMIT = (longint'(1) << CNT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // The sample that enters CHK_* is the first stable one, so the counter
  // reaches DEBOUNCE_CYCLES-2 on the cycle before the final stable sample.
  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 2);

  generate
    if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_LIMIT) begin : g_bad_debounce_cfg
      $error("key_debounce: DEBOUNCE_CYCLES does not fit CNT_W");
    end
  endgenerate

  logic             s1_q, s1_d, s2_q, s2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             flag_q, flag_d;
  logic             qualified;

  assign qualified = (cnt_q >= ACCEPT_AT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ST_LO;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    s1_d    = key_raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LO: begin
        if (s2_q) begin
          state_d = CHK_HI;
          cnt_d   = '0;
        end
      end
      CHK_HI: begin
        if (!s2_q) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (qualified) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (!s2_q) begin
          state_d = CHK_LO;
          cnt_d   = '0;
        end
      end
      CHK_LO: begin
        if (s2_q) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (qualified) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (state_q == CHK_HI && s2_q && qualified) begin
      level_d = 1'b1;
      press_d = 1'b1;
    end
    if (state_q == CHK_LO && !s2_q && qualified) begin
      level_d   = 1'b0;
      release_d = 1'b1;
    end
    // The set covers the whole visible key_press cycle so a coincident clear loses.
    flag_d = press_d | press_q | (flag_q & ~flag_clr);
  end

`ifdef KEY_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_AT = CNT_W'(LONG_CYCLES - 1);

  generate
    if (LONG_CYCLES < 1 || longint'(LONG_CYCLES) > CNT_LIMIT) begin : g_bad_long_cfg
      $error("key_debounce: LONG_CYCLES does not fit CNT_W");
    end
  endgenerate

  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  // Parking the counter one past LONG_AT suppresses a repeat pulse in the same press.
  always_comb begin
    lcnt_d = '0;
    long_d = 1'b0;
    if (state_q == ST_HI) begin
      lcnt_d = lcnt_q;
      if (lcnt_q < LONG_AT) begin
        lcnt_d = lcnt_q + CNT_W'(1);
      end else if (lcnt_q == LONG_AT) begin
        lcnt_d = lcnt_q + CNT_W'(1);
        long_d = 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign press_flag  = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_debounce
// Purpose  : Scoreboard bench for key_debounce against a run-length model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 10;
  localparam int W = 8;
`ifdef KEY_LONGPRESS_EN
  localparam int LP_EN = 1;
`else
  localparam int LP_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_raw = 1'b0;
  logic flag_clr = 1'b0;
  logic key_level, key_press, key_release, press_flag, long_press;

  key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (W),
    .LONG_CYCLES    (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .flag_clr   (flag_clr),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .press_flag (press_flag),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic flag;
    logic lp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: the level flips once D consecutive synchronised samples disagree with it.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_flag = 1'b0, m_press = 1'b0;
  int   m_run = 0;
  int   m_held = 0;

  always @(posedge clk) begin : model
    exp_t e;
    logic samp;
    logic p, r, lp;
    e = '0;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_flag = 0; m_press = 0;
      m_run = 0; m_held = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = key_raw;
      p = 0; r = 0; lp = 0;
      if (m_level && m_run == 0) begin
        m_held++;
        if (m_held == L) lp = (LP_EN != 0);
      end else begin
        m_held = 0;
      end
      if (samp != m_level) begin
        m_run++;
        if (m_run == D) begin
          m_level = samp;
          m_run   = 0;
          p = samp;
          r = !samp;
        end
      end else begin
        m_run = 0;
      end
      m_flag  = p | m_press | (m_flag & ~flag_clr);
      m_press = p;
      e = '{level: m_level, press: p, rel: r, flag: m_flag, lp: lp};
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{level: key_level, press: key_press, rel: key_release, flag: press_flag, lp: long_press};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got lvl/prs/rel/flg/lp=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({key_level, key_press, key_release, press_flag, long_press});
  endfunction

  initial begin : stim
    int npress, at, nlong, lat;
    logic [7:0] pat;
    int hold;
    logic v;

    // Reset held with the key pressed; re-qualification starts at release.
    key_raw = 1;
    repeat (3) tick();
    chk("in_reset_outputs", outs(), 0);
    rst = 1;
    chk("release_outputs", outs(), 0);
    repeat (5) tick();
    chk("reset_level_e5", int'(key_level), 0);
    tick();
    chk("reset_level_e6", int'(key_level), 1);
    chk("reset_press_e6", int'(key_press), 1);
    tick();
    chk("reset_press_gone", int'(key_press), 0);

    // Clean release.
    key_raw = 0;
    repeat (5) tick();
    chk("release_level_e5", int'(key_level), 1);
    tick();
    chk("release_pulse", int'(key_release), 1);
    chk("release_level_e6", int'(key_level), 0);
    chk("release_flag_kept", int'(press_flag), 1);
    tick();
    chk("release_pulse_gone", int'(key_release), 0);
    flag_clr = 1;
    tick();
    flag_clr = 0;
    chk("flag_cleared", int'(press_flag), 0);

    // Clean press, then hold for the long-press window.
    key_raw = 1;
    repeat (5) tick();
    chk("press_level_e5", int'(key_level), 0);
    tick();
    chk("press_level_e6", int'(key_level), 1);
    chk("press_pulse", int'(key_press), 1);
    nlong = 0; at = 0; npress = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (key_press) npress++;
      if (long_press) begin
        nlong++;
        at = i;
      end
    end
    chk("press_single_pulse", npress, 0);
    chk("press_flag_stays", int'(press_flag), 1);
    chk("long_count", nlong, LP_EN);
    chk("long_offset", at, LP_EN * L);

    // Bounce: the rising edge counts from the last 0->1.
    key_raw = 0;
    repeat (8) tick();
    pat = 8'b1111_1011;
    npress = 0; lat = 0;
    for (int i = 0; i < 12; i++) begin
      key_raw = (i < 8) ? pat[i] : 1'b1;
      tick();
      if (key_press) begin
        npress++;
        lat = i + 1;
      end
    end
    chk("bounce_press_count", npress, 1);
    chk("bounce_press_edge", lat, 9);

    // Coincident set and clear: set wins, lone clear then clears.
    key_raw = 0;
    repeat (8) tick();
    flag_clr = 1;
    tick();
    flag_clr = 0;
    key_raw = 1;
    repeat (6) tick();
    chk("coincide_press", int'(key_press), 1);
    flag_clr = 1;
    tick();
    flag_clr = 0;
    chk("coincide_flag_set", int'(press_flag), 1);
    flag_clr = 1;
    tick();
    flag_clr = 0;
    chk("lone_clear", int'(press_flag), 0);

    // Reset in the middle of a qualification.
    key_raw = 0;
    repeat (8) tick();
    key_raw = 1;
    repeat (4) tick();
    rst = 0;
    tick();
    chk("midqual_reset_outputs", outs(), 0);
    rst = 1;
    repeat (5) tick();
    chk("midqual_no_early_press", int'(key_level), 0);
    tick();
    chk("midqual_requalified", int'(key_press), 1);

    // Randomised bursts against the model.
    for (int n = 0; n < 120; n++) begin
      v    = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 25)) : int'($urandom_range(1, 6));
      for (int k = 0; k < hold; k++) begin
        key_raw  = v;
        flag_clr = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    flag_clr = 0;
    repeat (3) tick();
    chk("scoreboard_drained", int'(exp_q.size() <= 1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
